// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter among NUM_REQ producers.
// Holds a grant for a message burst, sequences tx_start/tx_done and inserts an idle gap between bursts.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int GAP_CYCLES   = 8,
    parameter int DONE_TIMEOUT = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;
    localparam logic [7:0]  BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [15:0] TO_LIMIT    = 16'(DONE_TIMEOUT - 1);
    localparam logic [8:0]  GAP_LIMIT   = 9'(GAP_CYCLES);

    typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT_DONE, GAP} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               timeout_err_q, timeout_err_d;
    logic               last_q, last_d;
    logic [7:0]         burst_q, burst_d;
    logic [15:0]        to_cnt_q, to_cnt_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;

    logic [IW-1:0] pick;
    logic          pick_vld;
    logic [SW-1:0] scan_sum;
    logic [IW-1:0] rr_next;
    logic          release_burst;
    logic          set_err;

    // Scan downward in offset so the closest set bit at or after rr_ptr is the last to overwrite pick.
    always_comb begin
        pick     = rr_ptr_q;
        pick_vld = 1'b0;
        scan_sum = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_sum = {1'b0, rr_ptr_q} + SW'(i);
            if (scan_sum >= SW'(NUM_REQ)) begin
                scan_sum = scan_sum - SW'(NUM_REQ);
            end
            if (req[scan_sum[IW-1:0]]) begin
                pick     = scan_sum[IW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign rr_next = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        req_ack_d     = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        burst_d       = burst_q;
        to_cnt_d      = to_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        release_burst = 1'b0;
        set_err       = 1'b0;

        case (state_q)
            IDLE: begin
                burst_d = '0;
                if (pick_vld) begin
                    owner_d       = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    release_burst = 1'b1;
                end else if (!tx_busy) begin
                    tx_data_d          = req_data[{owner_q, 3'b000} +: 8];
                    tx_start_d         = 1'b1;
                    req_ack_d[owner_q] = 1'b1;
                    last_d             = req_last[owner_q];
                    if (burst_q != 8'hFF) begin
                        burst_d = burst_q + 8'd1;
                    end
                    state_d = SEND;
                end
            end
            SEND: begin
                to_cnt_d = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                // tx_done is tested first so a completion on the timeout cycle is not flagged.
                if (tx_done) begin
                    if (last_q || burst_q >= BURST_LIMIT) begin
                        release_burst = 1'b1;
                    end else begin
                        state_d = GRANT;
                    end
                end else if (to_cnt_q >= TO_LIMIT) begin
                    set_err       = 1'b1;
                    release_burst = 1'b1;
                end else if (to_cnt_q != 16'hFFFF) begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (({1'b0, gap_cnt_q} + 9'd1) >= GAP_LIMIT) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (release_burst) begin
            grant_d   = '0;
            rr_ptr_d  = rr_next;
            gap_cnt_d = '0;
            state_d   = GAP;
        end

        if (err_clr) begin
            timeout_err_d = 1'b0;
        end else if (set_err) begin
            timeout_err_d = 1'b1;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // NOTE: non-blocking assignments make every flop sample the pre-edge value of its _d, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            req_ack_q     <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            timeout_err_q <= 1'b0;
            last_q        <= 1'b0;
            burst_q       <= '0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            req_ack_q     <= req_ack_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            timeout_err_q <= timeout_err_d;
            last_q        <= last_d;
            burst_q       <= burst_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign req_ack     = req_ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: producers and a TX core model drive the DUT,
// expected (owner, byte) pairs are queued by the stimulus and checked by a monitor on every tx_start.
module tb_uart_tx_arbiter;

    localparam int NR         = 4;
    localparam int MB         = 4;
    localparam int GAP        = 8;
    localparam int TO         = 100;
    localparam int DONE_DELAY = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   req_last = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   req_ack;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic            tx_done = 1'b0;
    logic            timeout_err;
    logic            err_clr = 1'b0;

    logic          model_busy = 1'b0;
    logic          busy_force = 1'b0;
    logic          done_en = 1'b1;
    logic          model_abort = 1'b0;
    logic [NR-1:0] flush_mask = '0;
    int            model_cnt = 0;
    int            done_cnt = 0;
    int            cyc = 0;
    int            last_start_cyc = 0;
    int            checks = 0;
    int            failures = 0;

    logic [8:0]  pmem [NR][64];
    int          phead [NR] = '{default: 0};
    int          ptail [NR] = '{default: 0};
    logic [11:0] exp_q [$];
    logic [11:0] mon_e;

    assign tx_busy = model_busy | busy_force;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .MAX_BURST    (MB),
        .GAP_CYCLES   (GAP),
        .DONE_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .grant       (grant),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        pmem[r][ptail[r]] = {l, d};
        ptail[r] = ptail[r] + 1;
    endtask

    task automatic expect_tx(input int r, input logic [7:0] d);
        logic [3:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        exp_q.push_back({oh, d});
    endtask

    task automatic wait_sent(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_grant(input string name, input logic [NR-1:0] v, input int budget);
        int n;
        n = 0;
        while (grant !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, grant, v);
    endtask

    // Producers: present the head byte of each FIFO and advance on req_ack.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (flush_mask[i]) phead[i] = ptail[i];
                else if (req_ack[i] && phead[i] < ptail[i]) phead[i] = phead[i] + 1;
                if (phead[i] < ptail[i]) begin
                    req[i]           = 1'b1;
                    req_data[8*i +: 8] = pmem[i][phead[i]][7:0];
                    req_last[i]      = pmem[i][phead[i]][8];
                end else begin
                    req[i]           = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]      = 1'b0;
                end
            end
        end
    end

    // UART TX core model: busy for DONE_DELAY cycles after tx_start, then a one-cycle tx_done.
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (model_abort) begin
                model_busy = 1'b0;
            end else if (model_busy) begin
                if (done_en) begin
                    model_cnt++;
                    if (model_cnt == DONE_DELAY) begin
                        tx_done    = 1'b1;
                        model_busy = 1'b0;
                        done_cnt++;
                    end
                end
            end else if (tx_start) begin
                model_busy = 1'b1;
                model_cnt  = 0;
            end
        end
    end

    // Monitor: compares every transmitted byte against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                if (tx_start) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tx_start: actual grant=%0h data=%0h required no transfer", grant, tx_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        last_start_cyc = cyc;
                        check("sb_grant", grant, mon_e[11:8]);
                        check("sb_tx_data", tx_data, mon_e[7:0]);
                        check("sb_req_ack", req_ack, mon_e[11:8]);
                    end
                end else if (req_ack != '0) begin
                    checks++;
                    failures++;
                    $display("FAIL stray_req_ack: actual=%0h required=0", req_ack);
                end
            end
        end
    end

    initial begin
        int n;
        int base_done;
        int acks;
        logic saw;

        // Reset values
        tick(3);
        check("rst_grant", grant, 0);
        check("rst_req_ack", req_ack, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        tick(2);

        // Single requester, two-byte message, then gap length before requester 3
        base_done = done_cnt;
        push_byte(0, 8'h55, 1'b0);
        push_byte(0, 8'hA3, 1'b1);
        expect_tx(0, 8'h55);
        expect_tx(0, 8'hA3);
        wait_sent("single", 200);
        push_byte(3, 8'h33, 1'b1);
        expect_tx(3, 8'h33);
        n = 0;
        while (grant != '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("single_drop_after_done2", done_cnt - base_done, 2);
        check("single_grant_released", grant, 0);
        // GAP_CYCLES cycles in GAP plus the IDLE arbitration cycle
        n = 0;
        while (grant == '0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("gap_idle_cycles", n, GAP + 1);
        check("gap_next_owner", grant, 4'b1000);
        wait_sent("gap_follow", 100);
        tick(30);

        // Round-robin with all four requesting, rr_ptr starting at 0
        push_byte(0, 8'hA0, 1'b1);
        push_byte(0, 8'hA4, 1'b1);
        push_byte(1, 8'hB1, 1'b1);
        push_byte(2, 8'hC2, 1'b1);
        push_byte(3, 8'hD3, 1'b1);
        expect_tx(0, 8'hA0);
        expect_tx(1, 8'hB1);
        expect_tx(2, 8'hC2);
        expect_tx(3, 8'hD3);
        expect_tx(0, 8'hA4);
        wait_sent("rr", 400);
        tick(30);

        // MAX_BURST=4: requester 2 streams 10 bytes, requester 3 cuts in after each burst
        for (int k = 0; k < 10; k++) push_byte(2, 8'h20 + 8'(k), (k == 9));
        push_byte(3, 8'h3C, 1'b1);
        for (int k = 0; k < 4; k++) expect_tx(2, 8'h20 + 8'(k));
        expect_tx(3, 8'h3C);
        for (int k = 4; k < 10; k++) expect_tx(2, 8'h20 + 8'(k));
        wait_sent("burst", 800);
        tick(30);

        // Timeout: no tx_done, flagged after 100 WAIT_DONE cycles
        done_en = 1'b0;
        push_byte(0, 8'h77, 1'b1);
        expect_tx(0, 8'h77);
        wait_sent("to_start", 100);
        n = 0;
        while (!timeout_err && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", cyc - last_start_cyc, TO + 1);
        check("timeout_grant_released", grant, 0);
        tick(3);
        check("timeout_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("timeout_cleared", timeout_err, 0);
        model_abort = 1'b1;
        tick(1);
        model_abort = 1'b0;
        done_en     = 1'b1;
        push_byte(1, 8'h88, 1'b1);
        expect_tx(1, 8'h88);
        wait_sent("to_recover", 200);
        tick(30);

        // err_clr held through a timeout: clear wins
        done_en = 1'b0;
        err_clr = 1'b1;
        push_byte(3, 8'h5A, 1'b1);
        expect_tx(3, 8'h5A);
        wait_sent("clr_start", 100);
        saw = 1'b0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            if (timeout_err) saw = 1'b1;
        end
        check("clr_beats_set", saw, 0);
        check("clr_grant_released", grant, 0);
        err_clr     = 1'b0;
        model_abort = 1'b1;
        tick(1);
        model_abort = 1'b0;
        done_en     = 1'b1;
        tick(20);

        // Owner drops req while stalled in GRANT: release without tx_start, rr_ptr advances
        busy_force = 1'b1;
        push_byte(1, 8'h99, 1'b0);
        wait_grant("drop_granted", 4'b0010, 50);
        tick(3);
        check("drop_grant_held", grant, 4'b0010);
        flush_mask = 4'b0010;
        n = 0;
        while (req[1] && n < 10) begin
            @(negedge clk);
            n++;
        end
        flush_mask = '0;
        @(negedge clk);
        check("drop_release", grant, 0);
        busy_force = 1'b0;
        push_byte(1, 8'h91, 1'b1);
        push_byte(2, 8'h92, 1'b1);
        expect_tx(2, 8'h92);
        expect_tx(1, 8'h91);
        wait_sent("drop_rr", 300);
        tick(30);

        // Reset during WAIT_DONE of a 3-byte burst from requester 3
        push_byte(3, 8'hE1, 1'b0);
        push_byte(3, 8'hE2, 1'b0);
        push_byte(3, 8'hE3, 1'b1);
        expect_tx(3, 8'hE1);
        wait_sent("rst_start", 100);
        tick(3);
        base_done  = done_cnt;
        flush_mask = 4'hF;
        rst        = 1'b1;
        @(negedge clk);
        check("midrst_grant", grant, 0);
        check("midrst_req_ack", req_ack, 0);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_timeout_err", timeout_err, 0);
        rst  = 1'b0;
        acks = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ack != '0 || tx_start) acks++;
        end
        check("stale_done_seen", done_cnt - base_done, 1);
        check("stale_done_no_ack", acks, 0);
        flush_mask = '0;
        tick(1);
        // rr_ptr back at 0: requester 1 wins over requester 3
        push_byte(1, 8'h1B, 1'b1);
        push_byte(3, 8'h3B, 1'b1);
        expect_tx(1, 8'h1B);
        expect_tx(3, 8'h3B);
        wait_sent("post_rst", 300);
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
